can_rx_frame_decoder: RTL and testbench
=======================================

// Module: can_rx_frame_decoder
// PURPOSE
//  Receive-side counterpart of the CAN transmitter. Consumes one sampled bus bit per sample point and
//  removes stuff bits. Parses standard and extended data/remote frames, checks CRC-15, drives the ACK
//  slot request and reports stuff/form/CRC errors. Sits between can_timing (sampled_bit, sample_point)
//  and the controller/error-management logic.
// PARAMETERS
//  CRC_POLY    15'h4599  CRC-15 generator x^15+x^14+x^10+x^8+x^7+x^4+x^3+1
//  IDLE_BITS   11        consecutive recessive samples needed to re-arm after an error
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous active-low reset
//  sample_point  in   1   one-cycle strobe, rx_bit valid
//  rx_bit        in   1   sampled bus level (0 = dominant)
//  abort         in   1   sync: drop current frame (error/overload frame started elsewhere)
//  rx_busy       out  1   frame in progress (SOF seen, not yet finished/aborted)
//  ack_req       out  1   request to drive dominant in ACK slot
//  rx_valid      out  1   one-cycle pulse: frame received error-free
//  rx_ide        out  1   extended frame
//  rx_rtr        out  1   remote frame
//  rx_id_std     out  11  base identifier
//  rx_id_ext     out  18  extension identifier (0 for standard)
//  rx_dlc        out  4   received DLC, raw
//  rx_data       out  64  byte k at [8k+7:8k], MSB first on bus; unused bytes 0
//  rx_crc        out  15  received CRC field
//  err_pulse     out  1   one-cycle pulse on any detected error
//  err_code      out  2   01 stuff, 10 form, 11 CRC; held until next err_pulse
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; stuff counter, CRC register and bit counter cleared.
//  All state updates happen only in cycles with sample_point=1, except abort and output pulses.
//  FSM: IDLE -> ID_STD(11) -> RTR_SRR -> IDE -> [IDE=1: ID_EXT(18) -> RTR -> R1] -> R0 -> DLC(4)
//   -> DATA(8*n) -> CRC(15) -> CRC_DLM -> ACK_SLOT -> ACK_DLM -> EOF(7) -> IDLE; any error -> WAIT_IDLE.
//  IDLE: sampled 0 = SOF; clears CRC, loads stuff run (level 0, count 1), rx_busy=1 next cycle.
//  n = rtr ? 0 : min(dlc,8); DLC 9..15 take 8 bytes; rx_dlc reports raw value. n=0 skips DATA.
//  Destuff window: SOF through last CRC bit. After 5 equal bits the next sample is a stuff bit:
//   it is discarded (no field/CRC update). Equal to the previous level -> stuff error.
//   A stuff bit starts a new run with count 1. The last CRC bit may be followed by a stuff bit.
//  CRC: shifted over destuffed SOF..last data bit: crc_nxt = bit ^ crc[14];
//   crc = {crc[13:0],1'b0} ^ (crc_nxt ? CRC_POLY : 0).
//  CRC_DLM must be 1, else form error. Else if rx_crc != computed CRC -> CRC error at that sample.
//  ack_req: 1 the cycle after CRC_DLM sample with no error; 0 the cycle after ACK_SLOT sample.
//   ACK_SLOT level is not checked.
//  ACK_DLM and EOF bits 1..6 must be 1, else form error. EOF bit 7 dominant is ignored
//   (overload is handled by the controller).
//  rx_valid: pulse the cycle after the EOF bit-7 sample. rx_* fields update together with that pulse,
//   then hold until the next rx_valid, so partial frames never appear on the outputs.
//  Error: err_pulse 1 cycle after the offending sample; rx_busy=0; ack_req=0; state WAIT_IDLE.
//   WAIT_IDLE returns to IDLE after IDLE_BITS consecutive recessive samples; a dominant sample
//   restarts the count.
//  abort: next cycle state=WAIT_IDLE, rx_busy=0, ack_req=0, no rx_valid/err_pulse; beats a sample.
//  rst_n low mid-frame: immediate return to reset values, no pulses.
// TESTING
//  1 Std data frame ID 0x123, DLC 2, data A5 5A, model-correct CRC, stuffed stream
//    -> rx_valid=1, rx_id_std=0x123, rx_ide=0, rx_data[15:0]=0x5AA5, ack_req high exactly over ACK slot.
//  2 Ext remote frame ID 0x1AB / ext 0x2_5C3D, RTR=1, DLC 4
//    -> rx_ide=1, rx_rtr=1, rx_dlc=4, rx_data=0, no DATA bits consumed, rx_valid.
//  3 Std frame ID 0x000, DLC 0 (long dominant runs, many stuff bits)
//    -> decoded ID 0x000, CRC match, rx_valid; stuff bits not shifted into the CRC.
//  4 Sixth equal bit instead of a stuff bit inside the ID
//    -> err_pulse, err_code=01, no rx_valid; dominant sample at idle count 10 restarts the count.
//  5 One data bit flipped in frame 1 with the original CRC -> err_code=11 at CRC_DLM, ack_req stays 0.
//  6 DLC=0xF with 8 bytes; CRC_DLM forced 0 -> form error 10. abort during DATA -> no pulses,
//    rx_busy=0 next cycle.

Source files
------------

// File: rtl/can_rx_frame_decoder_if.sv
// Sampled-bit input and decoded-frame output bundle of the CAN receive frame decoder.
interface can_rx_frame_decoder_if;
  logic        sample_point;
  logic        rx_bit;
  logic        abort;
  logic        rx_busy;
  logic        ack_req;
  logic        rx_valid;
  logic        rx_ide;
  logic        rx_rtr;
  logic [10:0] rx_id_std;
  logic [17:0] rx_id_ext;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic [14:0] rx_crc;
  logic        err_pulse;
  logic [1:0]  err_code;

  modport master (
    output sample_point, rx_bit, abort,
    input  rx_busy, ack_req, rx_valid, rx_ide, rx_rtr, rx_id_std, rx_id_ext,
           rx_dlc, rx_data, rx_crc, err_pulse, err_code
  );

  modport slave (
    input  sample_point, rx_bit, abort,
    output rx_busy, ack_req, rx_valid, rx_ide, rx_rtr, rx_id_std, rx_id_ext,
           rx_dlc, rx_data, rx_crc, err_pulse, err_code
  );
endinterface

// File: rtl/can_rx_frame_decoder.sv
// CAN receive frame decoder: destuffs the sampled bit stream, parses std/ext frames,
// checks CRC-15, requests the ACK slot and reports stuff/form/CRC errors.
module can_rx_frame_decoder #(
  parameter logic [14:0] CRC_POLY  = 15'h4599,
  parameter int unsigned IDLE_BITS = 11
) (
  input logic                   clk,
  input logic                   rst_n,
  can_rx_frame_decoder_if.slave bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_ID_STD, S_RTR_SRR, S_IDE, S_ID_EXT, S_RTR, S_R1, S_R0,
    S_DLC, S_DATA, S_CRC, S_CRC_DLM, S_ACK_SLOT, S_ACK_DLM, S_EOF, S_WAIT_IDLE
  } state_t;

  localparam logic [1:0] ERR_STUFF = 2'b01;
  localparam logic [1:0] ERR_FORM  = 2'b10;
  localparam logic [1:0] ERR_CRC   = 2'b11;
  localparam logic [3:0] IDLE_LAST = 4'(IDLE_BITS - 1);

  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic din);
    logic nxt;
    nxt = din ^ crc[14];
    crc15_step = {crc[13:0], 1'b0} ^ (nxt ? CRC_POLY : 15'h0000);
  endfunction

  state_t      state_r;
  logic        stuff_lvl_r;
  logic [2:0]  stuff_cnt_r;
  logic [6:0]  bit_cnt_r;
  logic [6:0]  data_bits_r;
  logic [3:0]  idle_cnt_r;
  logic [10:0] id_std_r;
  logic [17:0] id_ext_r;
  logic        rtr_r;
  logic        ide_r;
  logic [3:0]  dlc_r;
  logic [63:0] data_r;
  logic [14:0] crc_rx_r;
  logic [14:0] crc_calc_r;

  logic        in_window_s;
  logic        crc_window_s;
  logic        stuff_slot_s;
  logic [3:0]  dlc_nxt_s;
  logic [6:0]  nbits_s;
  logic [5:0]  data_idx_s;
  logic        err_det_s;
  logic [1:0]  err_code_s;

  assign in_window_s  = state_r inside {S_ID_STD, S_RTR_SRR, S_IDE, S_ID_EXT, S_RTR, S_R1,
                                        S_R0, S_DLC, S_DATA, S_CRC};
  assign crc_window_s = in_window_s && (state_r != S_CRC);
  // The sample after the last CRC bit can still be a stuff bit, hence CRC_DLM here.
  assign stuff_slot_s = (in_window_s || (state_r == S_CRC_DLM)) && (stuff_cnt_r == 3'd5);
  assign dlc_nxt_s    = {dlc_r[2:0], bus.rx_bit};
  assign nbits_s      = rtr_r ? 7'd0 : {(dlc_nxt_s[3] ? 4'd8 : {1'b0, dlc_nxt_s[2:0]}), 3'b000};
  assign data_idx_s   = {bit_cnt_r[5:3], ~bit_cnt_r[2:0]};

  // Error detection for the current sample.
  always_comb begin
    err_det_s  = 1'b0;
    err_code_s = 2'b00;
    if (bus.sample_point && !bus.abort) begin
      if (stuff_slot_s) begin
        if (bus.rx_bit == stuff_lvl_r) begin
          err_det_s  = 1'b1;
          err_code_s = ERR_STUFF;
        end else begin
          err_det_s  = 1'b0;
        end
      end else begin
        case (state_r)
          S_CRC_DLM: begin
            if (!bus.rx_bit) begin
              err_det_s  = 1'b1;
              err_code_s = ERR_FORM;
            end else if (crc_rx_r != crc_calc_r) begin
              err_det_s  = 1'b1;
              err_code_s = ERR_CRC;
            end else begin
              err_det_s  = 1'b0;
            end
          end
          S_ACK_DLM: begin
            err_det_s  = !bus.rx_bit;
            err_code_s = ERR_FORM;
          end
          S_EOF: begin
            err_det_s  = !bus.rx_bit && (bit_cnt_r != 7'd6);
            err_code_s = ERR_FORM;
          end
          default: begin
            err_det_s  = 1'b0;
            err_code_s = 2'b00;
          end
        endcase
      end
    end else begin
      err_det_s = 1'b0;
    end
  end

  // Frame FSM, destuffing, CRC accumulation and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      stuff_lvl_r   <= 1'b0;
      stuff_cnt_r   <= 3'd0;
      bit_cnt_r     <= 7'd0;
      data_bits_r   <= 7'd0;
      idle_cnt_r    <= 4'd0;
      id_std_r      <= 11'd0;
      id_ext_r      <= 18'd0;
      rtr_r         <= 1'b0;
      ide_r         <= 1'b0;
      dlc_r         <= 4'd0;
      data_r        <= 64'd0;
      crc_rx_r      <= 15'd0;
      crc_calc_r    <= 15'd0;
      bus.rx_busy   <= 1'b0;
      bus.ack_req   <= 1'b0;
      bus.rx_valid  <= 1'b0;
      bus.rx_ide    <= 1'b0;
      bus.rx_rtr    <= 1'b0;
      bus.rx_id_std <= 11'd0;
      bus.rx_id_ext <= 18'd0;
      bus.rx_dlc    <= 4'd0;
      bus.rx_data   <= 64'd0;
      bus.rx_crc    <= 15'd0;
      bus.err_pulse <= 1'b0;
      bus.err_code  <= 2'b00;
    end else begin
      bus.rx_valid  <= 1'b0;
      bus.err_pulse <= 1'b0;
      if (bus.abort) begin
        state_r     <= S_WAIT_IDLE;
        idle_cnt_r  <= 4'd0;
        bus.rx_busy <= 1'b0;
        bus.ack_req <= 1'b0;
      end else if (err_det_s) begin
        state_r       <= S_WAIT_IDLE;
        idle_cnt_r    <= 4'd0;
        bus.rx_busy   <= 1'b0;
        bus.ack_req   <= 1'b0;
        bus.err_pulse <= 1'b1;
        bus.err_code  <= err_code_s;
      end else if (bus.sample_point) begin
        if (stuff_slot_s) begin
          stuff_lvl_r <= bus.rx_bit;
          stuff_cnt_r <= 3'd1;
        end else begin
          if (in_window_s) begin
            if (bus.rx_bit == stuff_lvl_r) begin
              stuff_cnt_r <= stuff_cnt_r + 3'd1;
            end else begin
              stuff_lvl_r <= bus.rx_bit;
              stuff_cnt_r <= 3'd1;
            end
          end
          if (crc_window_s) begin
            crc_calc_r <= crc15_step(crc_calc_r, bus.rx_bit);
          end
          case (state_r)
            S_IDLE: begin
              if (!bus.rx_bit) begin
                state_r     <= S_ID_STD;
                stuff_lvl_r <= 1'b0;
                stuff_cnt_r <= 3'd1;
                crc_calc_r  <= 15'd0;
                bit_cnt_r   <= 7'd0;
                id_ext_r    <= 18'd0;
                data_r      <= 64'd0;
                bus.rx_busy <= 1'b1;
              end
            end
            S_ID_STD: begin
              id_std_r  <= {id_std_r[9:0], bus.rx_bit};
              bit_cnt_r <= (bit_cnt_r == 7'd10) ? 7'd0 : bit_cnt_r + 7'd1;
              if (bit_cnt_r == 7'd10) state_r <= S_RTR_SRR;
            end
            S_RTR_SRR: begin
              rtr_r   <= bus.rx_bit;
              state_r <= S_IDE;
            end
            S_IDE: begin
              ide_r     <= bus.rx_bit;
              bit_cnt_r <= 7'd0;
              state_r   <= bus.rx_bit ? S_ID_EXT : S_R0;
            end
            S_ID_EXT: begin
              id_ext_r  <= {id_ext_r[16:0], bus.rx_bit};
              bit_cnt_r <= (bit_cnt_r == 7'd17) ? 7'd0 : bit_cnt_r + 7'd1;
              if (bit_cnt_r == 7'd17) state_r <= S_RTR;
            end
            S_RTR: begin
              rtr_r   <= bus.rx_bit;
              state_r <= S_R1;
            end
            S_R1: state_r <= S_R0;
            S_R0: begin
              bit_cnt_r <= 7'd0;
              state_r   <= S_DLC;
            end
            S_DLC: begin
              dlc_r     <= dlc_nxt_s;
              bit_cnt_r <= (bit_cnt_r == 7'd3) ? 7'd0 : bit_cnt_r + 7'd1;
              if (bit_cnt_r == 7'd3) begin
                data_bits_r <= nbits_s;
                state_r     <= (nbits_s == 7'd0) ? S_CRC : S_DATA;
              end
            end
            S_DATA: begin
              data_r[data_idx_s] <= bus.rx_bit;
              bit_cnt_r <= (bit_cnt_r == data_bits_r - 7'd1) ? 7'd0 : bit_cnt_r + 7'd1;
              if (bit_cnt_r == data_bits_r - 7'd1) state_r <= S_CRC;
            end
            S_CRC: begin
              crc_rx_r  <= {crc_rx_r[13:0], bus.rx_bit};
              bit_cnt_r <= (bit_cnt_r == 7'd14) ? 7'd0 : bit_cnt_r + 7'd1;
              if (bit_cnt_r == 7'd14) state_r <= S_CRC_DLM;
            end
            S_CRC_DLM: begin
              bus.ack_req <= 1'b1;
              state_r     <= S_ACK_SLOT;
            end
            S_ACK_SLOT: begin
              bus.ack_req <= 1'b0;
              state_r     <= S_ACK_DLM;
            end
            S_ACK_DLM: begin
              bit_cnt_r <= 7'd0;
              state_r   <= S_EOF;
            end
            S_EOF: begin
              bit_cnt_r <= bit_cnt_r + 7'd1;
              if (bit_cnt_r == 7'd6) begin
                state_r       <= S_IDLE;
                bus.rx_busy   <= 1'b0;
                bus.rx_valid  <= 1'b1;
                bus.rx_ide    <= ide_r;
                bus.rx_rtr    <= rtr_r;
                bus.rx_id_std <= id_std_r;
                bus.rx_id_ext <= id_ext_r;
                bus.rx_dlc    <= dlc_r;
                bus.rx_data   <= data_r;
                bus.rx_crc    <= crc_rx_r;
              end
            end
            S_WAIT_IDLE: begin
              if (!bus.rx_bit) begin
                idle_cnt_r <= 4'd0;
              end else if (idle_cnt_r == IDLE_LAST) begin
                state_r <= S_IDLE;
              end else begin
                idle_cnt_r <= idle_cnt_r + 4'd1;
              end
            end
            default: state_r <= S_WAIT_IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_can_rx_frame_decoder.sv
// Scoreboard bench for can_rx_frame_decoder: frames are built and bit-stuffed here,
// expected results are queued at issue time and a monitor checks every output pulse.
module tb_can_rx_frame_decoder;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  can_rx_frame_decoder_if bus ();

  can_rx_frame_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        is_err;
    logic [1:0]  code;
    logic        ide;
    logic        rtr;
    logic [10:0] id_std;
    logic [17:0] id_ext;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [14:0] crc;
  } exp_t;

  exp_t sb_q[$];
  logic stream_q[$];
  int   ack_idx;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Raw frame bits SOF..CRC are stuffed, then the fixed-form tail is appended.
  task automatic build_frame(input logic [10:0] id, input logic ide, input logic [17:0] ext,
                             input logic rtr, input logic [3:0] dlc, input logic [63:0] data,
                             input int flip_idx, input logic dlm, output logic [14:0] crc);
    logic raw[$];
    logic nxt;
    logic last;
    int   nb;
    int   run;
    raw = {};
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    if (ide) begin
      raw.push_back(1'b1);
      raw.push_back(1'b1);
      for (int i = 17; i >= 0; i--) raw.push_back(ext[i]);
      raw.push_back(rtr);
      raw.push_back(1'b0);
      raw.push_back(1'b0);
    end else begin
      raw.push_back(rtr);
      raw.push_back(1'b0);
      raw.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    nb = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int k = 0; k < nb; k++)
      for (int i = 7; i >= 0; i--) raw.push_back(data[8*k+i]);
    crc = 15'd0;
    foreach (raw[i]) begin
      nxt = raw[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (nxt) crc = crc ^ 15'h4599;
    end
    if (flip_idx >= 0) raw[flip_idx] = ~raw[flip_idx];
    for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
    stream_q = {};
    last = 1'b1;
    run  = 0;
    foreach (raw[i]) begin
      stream_q.push_back(raw[i]);
      if (raw[i] == last) run++;
      else begin
        last = raw[i];
        run  = 1;
      end
      if (run == 5) begin
        stream_q.push_back(~last);
        last = ~last;
        run  = 1;
      end
    end
    stream_q.push_back(dlm);
    ack_idx = stream_q.size();
    stream_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) stream_q.push_back(1'b1);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.rx_bit       = b;
    bus.sample_point = 1'b1;
    @(negedge clk);
    bus.sample_point = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  // ack_req must be high only while the ACK slot bit is being presented.
  task automatic send_stream(input string name, input logic expect_ack, input int upto);
    int bad = 0;
    for (int i = 0; i < upto; i++) begin
      if (bus.ack_req !== (expect_ack && (i == ack_idx))) bad++;
      send_bit(stream_q[i]);
    end
    check(name, 64'(bad), 64'd0);
  endtask

  function automatic exp_t mk_ok(input logic [10:0] id, input logic ide, input logic [17:0] ext,
                                 input logic rtr, input logic [3:0] dlc, input logic [63:0] data,
                                 input logic [14:0] crc);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'b00; e.ide = ide; e.rtr = rtr; e.id_std = id;
    e.id_ext = ext; e.dlc = dlc; e.data = data; e.crc = crc;
    return e;
  endfunction

  function automatic exp_t mk_err(input logic [1:0] code);
    exp_t e;
    e = mk_ok(11'd0, 1'b0, 18'd0, 1'b0, 4'd0, 64'd0, 15'd0);
    e.is_err = 1'b1;
    e.code   = code;
    return e;
  endfunction

  // Monitor: every rx_valid/err_pulse consumes one scoreboard entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.rx_valid || bus.err_pulse) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual=valid:%0b,err:%0b required=none",
                   bus.rx_valid, bus.err_pulse);
        end else begin
          e = sb_q.pop_front();
          check("pulse_err", 64'(bus.err_pulse), 64'(e.is_err));
          check("pulse_valid", 64'(bus.rx_valid), 64'(!e.is_err));
          if (e.is_err) begin
            check("err_code", 64'(bus.err_code), 64'(e.code));
          end else begin
            check("rx_id_std", 64'(bus.rx_id_std), 64'(e.id_std));
            check("rx_id_ext", 64'(bus.rx_id_ext), 64'(e.id_ext));
            check("rx_ide", 64'(bus.rx_ide), 64'(e.ide));
            check("rx_rtr", 64'(bus.rx_rtr), 64'(e.rtr));
            check("rx_dlc", 64'(bus.rx_dlc), 64'(e.dlc));
            check("rx_data", bus.rx_data, e.data);
            check("rx_crc", 64'(bus.rx_crc), 64'(e.crc));
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [14:0] crc;
    bus.sample_point = 1'b0;
    bus.rx_bit       = 1'b1;
    bus.abort        = 1'b0;
    rst_n            = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({bus.rx_busy, bus.ack_req, bus.rx_valid, bus.rx_ide, bus.rx_rtr,
                               bus.rx_id_std, bus.rx_id_ext, bus.rx_dlc, bus.rx_crc,
                               bus.err_pulse, bus.err_code}), 64'd0);
    check("reset_data", bus.rx_data, 64'd0);
    rst_n = 1'b1;
    idle(12);

    // Standard data frame 0x123, DLC 2, A5 5A.
    build_frame(11'h123, 1'b0, 18'd0, 1'b0, 4'd2, 64'h5AA5, -1, 1'b1, crc);
    sb_q.push_back(mk_ok(11'h123, 1'b0, 18'd0, 1'b0, 4'd2, 64'h5AA5, crc));
    send_stream("ack_window_std", 1'b1, stream_q.size());
    idle(11);

    // Extended remote frame, DLC 4 but no data field.
    build_frame(11'h1AB, 1'b1, 18'h25C3D, 1'b1, 4'd4, 64'd0, -1, 1'b1, crc);
    sb_q.push_back(mk_ok(11'h1AB, 1'b1, 18'h25C3D, 1'b1, 4'd4, 64'd0, crc));
    send_stream("ack_window_ext_rtr", 1'b1, stream_q.size());
    idle(11);

    // All-dominant ID, DLC 0: heavy stuffing.
    build_frame(11'h000, 1'b0, 18'd0, 1'b0, 4'd0, 64'd0, -1, 1'b1, crc);
    sb_q.push_back(mk_ok(11'h000, 1'b0, 18'd0, 1'b0, 4'd0, 64'd0, crc));
    send_stream("ack_window_zero", 1'b1, stream_q.size());
    idle(11);

    // Sixth dominant bit where a stuff bit belongs.
    sb_q.push_back(mk_err(2'b01));
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    idle(10);
    send_bit(1'b0);
    idle(10);
    send_bit(1'b0);
    check("wait_idle_restart", 64'(bus.rx_busy), 64'd0);
    idle(11);

    // Data bit flipped, original CRC kept.
    build_frame(11'h123, 1'b0, 18'd0, 1'b0, 4'd2, 64'h5AA5, 20, 1'b1, crc);
    sb_q.push_back(mk_err(2'b11));
    send_stream("ack_stays_low_crc_err", 1'b0, stream_q.size());
    idle(11);

    // DLC 15 carries 8 bytes.
    build_frame(11'h7F0, 1'b0, 18'd0, 1'b0, 4'hF, 64'h0123456789ABCDEF, -1, 1'b1, crc);
    sb_q.push_back(mk_ok(11'h7F0, 1'b0, 18'd0, 1'b0, 4'hF, 64'h0123456789ABCDEF, crc));
    send_stream("ack_window_dlc15", 1'b1, stream_q.size());
    idle(11);

    // Same frame with dominant CRC delimiter.
    build_frame(11'h7F0, 1'b0, 18'd0, 1'b0, 4'hF, 64'h0123456789ABCDEF, -1, 1'b0, crc);
    sb_q.push_back(mk_err(2'b10));
    send_stream("ack_stays_low_form_err", 1'b0, stream_q.size());
    idle(11);

    // Abort coinciding with a sample inside DATA.
    build_frame(11'h055, 1'b0, 18'd0, 1'b0, 4'd8, 64'hFFEEDDCCBBAA9988, -1, 1'b1, crc);
    send_stream("ack_low_before_abort", 1'b0, 30);
    check("busy_before_abort", 64'(bus.rx_busy), 64'd1);
    @(negedge clk);
    bus.rx_bit       = stream_q[30];
    bus.sample_point = 1'b1;
    bus.abort        = 1'b1;
    @(negedge clk);
    bus.sample_point = 1'b0;
    bus.abort        = 1'b0;
    check("abort_busy", 64'(bus.rx_busy), 64'd0);
    for (int i = 31; i < stream_q.size(); i++) send_bit(stream_q[i]);
    idle(11);

    // Reset mid-frame clears everything without pulses.
    build_frame(11'h123, 1'b0, 18'd0, 1'b0, 4'd2, 64'h5AA5, -1, 1'b1, crc);
    send_stream("ack_low_before_reset", 1'b0, 20);
    check("busy_before_reset", 64'(bus.rx_busy), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_frame", 64'({bus.rx_busy, bus.rx_id_std, bus.rx_dlc, bus.err_code}), 64'd0);
    rst_n = 1'b1;
    idle(12);

    // Recovery frame after reset.
    sb_q.push_back(mk_ok(11'h123, 1'b0, 18'd0, 1'b0, 4'd2, 64'h5AA5, crc));
    send_stream("ack_window_recovery", 1'b1, stream_q.size());
    idle(4);
    repeat (10) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
